// File: rtl/result_store_responder.sv
// Responder side of the result-store handshake: latches a batch of per-core detections and
// writes one record per detecting core, then a terminating exit record carrying the count.
module result_store_responder #(
    parameter int                CORES     = 32,
    parameter int                XBITS     = 12,
    parameter int                YBITS     = 11,
    parameter int                SBITS     = 8,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_REC   = 4096
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [XBITS-1:0]  startX_i,
    input  logic [YBITS-1:0]  startY_i,
    input  logic [SBITS-1:0]  scale_i,
    input  logic              exit_i,
    input  logic [CORES-1:0]  detect_i,
    output logic              ready_o,
    output logic              done_o,
    output logic              overflow_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic              wr_en_o,
    input  logic              wr_wait_i
);

    localparam int IDX_W = (CORES > 1) ? $clog2(CORES) : 1;
    localparam int CNT_W = $clog2(MAX_REC) + 1;

    typedef enum logic [1:0] {IDLE, WRITE, EXIT, DONE} state_e;

    state_e             state_q, state_d;
    logic [CORES-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [XBITS-1:0]   x_q;
    logic [YBITS-1:0]   y_q;
    logic [SBITS-1:0]   s_q;
    logic               load;
    logic [IDX_W-1:0]   idx;
    logic [XBITS-1:0]   xSum;
    logic [31:0]        detRecord;
    logic [31:0]        exitRecord;
    logic               hasRoom;

    // Lowest set bit wins so a batch is written in ascending core order.
    always_comb begin
        idx = '0;
        for (int i = CORES - 1; i >= 0; i--) begin
            if (mask_q[i]) idx = IDX_W'(i);
        end
    end

    assign xSum       = x_q + XBITS'(idx);
    assign detRecord  = {1'b0, 8'(s_q), 11'(y_q), 12'(xSum)};
    assign exitRecord = {1'b1, 31'(count_q)};
    assign hasRoom    = (count_q < CNT_W'(MAX_REC - 1));
    assign wr_addr_o  = BASE_ADDR + (ADDR_W'(count_q) << 2);
    assign overflow_o = overflow_q;

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        load       = 1'b0;
        ready_o    = 1'b0;
        done_o     = 1'b0;
        wr_en_o    = 1'b0;
        wr_data_o  = '0;
        unique case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    load    = 1'b1;
                    mask_d  = exit_i ? '0 : detect_i;
                    state_d = exit_i ? EXIT : WRITE;
                end
            end
            WRITE: begin
                if (mask_q == '0) begin
                    state_d = IDLE;
                end else if (hasRoom) begin
                    wr_en_o   = 1'b1;
                    wr_data_o = detRecord;
                    if (!wr_wait_i) begin
                        mask_d[idx] = 1'b0;
                        count_d     = count_q + 1'b1;
                    end
                end else begin
                    // Last slot is kept for the exit record; the rest of the batch is lost.
                    overflow_d = 1'b1;
                    mask_d     = '0;
                end
            end
            EXIT: begin
                wr_en_o   = 1'b1;
                wr_data_o = exitRecord;
                if (!wr_wait_i) state_d = DONE;
            end
            DONE: begin
                done_o = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q <= '0;
            y_q <= '0;
            s_q <= '0;
        end else if (load) begin
            x_q <= startX_i;
            y_q <= startY_i;
            s_q <= scale_i;
        end
    end

endmodule

// File: tb/tb_result_store_responder.sv
// Directed self-checking bench for result_store_responder: a default-size instance plus a
// four-slot instance used to exercise the store-full and reserved exit-slot behaviour.
module tb_result_store_responder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] startX;
    logic [10:0] startY;
    logic [7:0]  scale;
    logic        exitReq;
    logic [31:0] detect;
    logic        wrWait;
    logic        ready;
    logic        done;
    logic        overflow;
    logic [31:0] wrAddr;
    logic [31:0] wrData;
    logic        wrEn;

    logic        sStart;
    logic        sExit;
    logic [31:0] sDetect;
    logic        sWait;
    logic        sReady;
    logic        sDone;
    logic        sOverflow;
    logic [31:0] sWrAddr;
    logic [31:0] sWrData;
    logic        sWrEn;

    int testsRun    = 0;
    int testsFailed = 0;

    result_store_responder dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .startX_i   (startX),
        .startY_i   (startY),
        .scale_i    (scale),
        .exit_i     (exitReq),
        .detect_i   (detect),
        .ready_o    (ready),
        .done_o     (done),
        .overflow_o (overflow),
        .wr_addr_o  (wrAddr),
        .wr_data_o  (wrData),
        .wr_en_o    (wrEn),
        .wr_wait_i  (wrWait)
    );

    result_store_responder #(.MAX_REC(4)) dutSmall (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (sStart),
        .startX_i   (startX),
        .startY_i   (startY),
        .scale_i    (scale),
        .exit_i     (sExit),
        .detect_i   (sDetect),
        .ready_o    (sReady),
        .done_o     (sDone),
        .overflow_o (sOverflow),
        .wr_addr_o  (sWrAddr),
        .wr_data_o  (sWrData),
        .wr_en_o    (sWrEn),
        .wr_wait_i  (sWait)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkWrite(input string tag, input logic [31:0] addr, input logic [31:0] data);
        checkOutput({tag, " wr_en"}, 32'(wrEn), 32'd1);
        checkOutput({tag, " addr"}, wrAddr, addr);
        checkOutput({tag, " data"}, wrData, data);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; startX = '0; startY = '0; scale = '0;
        exitReq = 1'b0; detect = '0; wrWait = 1'b0;
        sStart = 1'b0; sExit = 1'b0; sDetect = '0; sWait = 1'b0;
        #12;
        checkOutput("reset ready", 32'(ready), 32'd1);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset overflow", 32'(overflow), 32'd0);
        checkOutput("reset wr_en", 32'(wrEn), 32'd0);
        checkOutput("reset addr", wrAddr, 32'd0);
        checkOutput("reset data", wrData, 32'd0);
        rst_n = 1'b1;
        tick();

        // Four-slot store: 2 + 1 writes, then the rest of the second batch is dropped.
        startX = 12'd8; startY = '0; scale = '0; sDetect = 32'b11; sStart = 1'b1;
        tick();
        sStart = 1'b0;
        checkOutput("small b1 w0 data", sWrData, 32'd8);
        checkOutput("small b1 w0 addr", sWrAddr, 32'd0);
        tick();
        checkOutput("small b1 w1 data", sWrData, 32'd9);
        checkOutput("small b1 w1 addr", sWrAddr, 32'd4);
        tick();
        checkOutput("small b1 end wr_en", 32'(sWrEn), 32'd0);
        tick();
        checkOutput("small b1 ready", 32'(sReady), 32'd1);
        sStart = 1'b1;
        tick();
        sStart = 1'b0;
        checkOutput("small b2 w0 wr_en", 32'(sWrEn), 32'd1);
        checkOutput("small b2 w0 data", sWrData, 32'd8);
        checkOutput("small b2 w0 addr", sWrAddr, 32'd8);
        tick();
        checkOutput("small full wr_en", 32'(sWrEn), 32'd0);
        checkOutput("small overflow early", 32'(sOverflow), 32'd0);
        tick();
        checkOutput("small overflow set", 32'(sOverflow), 32'd1);
        checkOutput("small full no write", 32'(sWrEn), 32'd0);
        tick();
        checkOutput("small b2 ready", 32'(sReady), 32'd1);
        checkOutput("small count addr", sWrAddr, 32'd12);
        sExit = 1'b1; sStart = 1'b1;
        tick();
        sExit = 1'b0; sStart = 1'b0;
        checkOutput("small exit wr_en", 32'(sWrEn), 32'd1);
        checkOutput("small exit addr", sWrAddr, 32'd12);
        checkOutput("small exit data", sWrData, 32'h8000_0003);
        tick();
        checkOutput("small done", 32'(sDone), 32'd1);
        checkOutput("small overflow sticky", 32'(sOverflow), 32'd1);

        // Batch with cores 0, 1 and 3; detect changes after acceptance must not matter.
        startX = 12'd10; startY = 11'd5; scale = 8'd2; detect = 32'b1011; start = 1'b1;
        tick();
        start = 1'b0; detect = '1;
        checkOutput("b1 ready low", 32'(ready), 32'd0);
        checkWrite("b1 w0", 32'd0, 32'h0100_500A);
        tick();
        checkWrite("b1 w1", 32'd4, 32'h0100_500B);
        tick();
        checkWrite("b1 w2", 32'd8, 32'h0100_500D);
        tick();
        checkOutput("b1 end wr_en", 32'(wrEn), 32'd0);
        checkOutput("b1 end ready", 32'(ready), 32'd0);
        tick();
        checkOutput("b1 ready back", 32'(ready), 32'd1);

        // Empty batch: one cycle of ready low, no write.
        detect = '0; start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("empty ready low", 32'(ready), 32'd0);
        checkOutput("empty wr_en", 32'(wrEn), 32'd0);
        tick();
        checkOutput("empty ready back", 32'(ready), 32'd1);
        checkOutput("empty count", wrAddr, 32'd12);

        // Stalled write, with a stray start while busy.
        startX = 12'd100; startY = 11'd7; scale = 8'd1; detect = 32'd1 << 5; wrWait = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; detect = '1;
        for (int k = 0; k < 4; k++) begin
            checkWrite($sformatf("stall c%0d", k), 32'd12, 32'h0080_7069);
            start = (k == 1);
            tick();
        end
        start = 1'b0; wrWait = 1'b0;
        checkWrite("stall release", 32'd12, 32'h0080_7069);
        tick();
        checkOutput("stall once wr_en", 32'(wrEn), 32'd0);
        checkOutput("stall once addr", wrAddr, 32'd16);
        tick();
        checkOutput("stall ready", 32'(ready), 32'd1);
        tick();
        checkOutput("busy start ignored", 32'(wrEn), 32'd0);
        checkOutput("busy start addr", wrAddr, 32'd16);

        // X wraps modulo 4096 for core 31.
        startX = 12'd4095; startY = 11'd1; scale = 8'd255; detect = 32'h8000_0000; start = 1'b1;
        tick();
        start = 1'b0;
        checkWrite("wrap", 32'd16, 32'h7F80_101E);
        tick();
        tick();
        checkOutput("wrap ready", 32'(ready), 32'd1);

        // Exit after five records.
        exitReq = 1'b1; start = 1'b1;
        tick();
        exitReq = 1'b0; start = 1'b0;
        checkWrite("exit", 32'd20, 32'h8000_0005);
        checkOutput("exit ready", 32'(ready), 32'd0);
        tick();
        checkOutput("done", 32'(done), 32'd1);
        checkOutput("done wr_en", 32'(wrEn), 32'd0);
        start = 1'b1; detect = '1;
        tick();
        tick();
        start = 1'b0;
        checkOutput("done sticky", 32'(done), 32'd1);
        checkOutput("done no write", 32'(wrEn), 32'd0);
        checkOutput("done ready", 32'(ready), 32'd0);
        checkOutput("overflow clear", 32'(overflow), 32'd0);

        // Reset in the middle of a stalled write.
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        startX = 12'd3; startY = '0; scale = '0; detect = 32'd1; wrWait = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        checkWrite("prereset", 32'd0, 32'd3);
        tick();
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midreset wr_en", 32'(wrEn), 32'd0);
        checkOutput("midreset ready", 32'(ready), 32'd1);
        checkOutput("midreset addr", wrAddr, 32'd0);
        checkOutput("midreset done", 32'(done), 32'd0);
        checkOutput("midreset small ovf", 32'(sOverflow), 32'd0);
        rst_n = 1'b1; wrWait = 1'b0;
        startX = '0; detect = 32'b100; start = 1'b1;
        tick();
        start = 1'b0;
        checkWrite("postreset", 32'd0, 32'd2);
        tick();
        checkOutput("postreset end", 32'(wrEn), 32'd0);
        tick();
        checkOutput("postreset ready", 32'(ready), 32'd1);
        checkOutput("postreset addr", wrAddr, 32'd4);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
